// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round/level sequencer driving game_logic config, red/green light schedule,
// lives and level progression from the game_logic status code.
module game_round_ctrl #(
  parameter int LEVELS     = 4,
  parameter int LIVES      = 3,
  parameter int TICK_DIV   = 16,
  parameter int GREEN_BASE = 6,
  parameter int RED_BASE   = 4,
  parameter int CLICKS_L0  = 14,
  parameter int STEPS      = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] status_code,
  input  logic [3:0] position,
  output logic       enable,
  output logic       red,
  output logic       win,
  output logic [3:0] max_clicks,
  output logic [3:0] max_steps,
  output logic [1:0] level,
  output logic [1:0] lives,
  output logic       round_done,
  output logic       game_over,
  output logic       cleared
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = 8;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_PLAY, S_RESULT, S_OVER} state_t;

  state_t          r_state, w_state_n;
  logic            r_start_q, r_red, r_win, r_succ, r_cleared, w_cleared_n;
  logic [PW-1:0]   r_presc;
  logic [TW-1:0]   r_timer, w_timer_dn;
  logic [1:0]      r_level, w_level_n, r_lives, w_lives_n;
  logic [3:0]      r_max_clicks, r_max_steps;
  logic            w_edge, w_tick, w_won, w_lost, w_stay;

  function automatic logic [TW-1:0] green_len(input logic [1:0] lv);
    int g;
    g = GREEN_BASE - int'(lv);
    return TW'(g < 2 ? 2 : g);
  endfunction

  function automatic logic [TW-1:0] red_len(input logic [1:0] lv);
    return TW'(RED_BASE + int'(lv));
  endfunction

  function automatic logic [3:0] clicks(input logic [1:0] lv);
    int c;
    c = CLICKS_L0 - 2 * int'(lv);
    return 4'(c < 4 ? 4 : c);
  endfunction

  assign w_edge     = start & ~r_start_q;
  assign w_tick     = r_presc == PW'(TICK_DIV - 1);
  assign w_won      = status_code == 4'd2;
  assign w_lost     = status_code == 4'd3;
  assign w_stay     = (r_state == S_PLAY) && (w_state_n == S_PLAY);
  assign w_timer_dn = r_timer == '0 ? '0 : r_timer - 1'b1;

  always_comb begin
    w_state_n   = r_state;
    w_level_n   = r_level;
    w_lives_n   = r_lives;
    w_cleared_n = r_cleared;
    case (r_state)
      S_IDLE: if (w_edge) begin
        w_state_n = S_ARM;
        w_level_n = 2'd0;
        w_lives_n = 2'(LIVES);
      end
      S_ARM:  w_state_n = S_PLAY;
      S_PLAY: w_state_n = (w_won || w_lost) ? S_RESULT : S_PLAY;
      S_RESULT: if (r_succ) begin
        w_state_n   = (r_level == 2'(LEVELS - 1)) ? S_OVER : S_ARM;
        w_level_n   = (r_level == 2'(LEVELS - 1)) ? r_level : r_level + 2'd1;
        w_cleared_n = r_level == 2'(LEVELS - 1);
      end else begin
        w_lives_n = r_lives == 2'd0 ? 2'd0 : r_lives - 2'd1;
        w_state_n = w_lives_n == 2'd0 ? S_OVER : S_ARM;
      end
      S_OVER: if (w_edge) begin
        w_state_n   = S_ARM;
        w_level_n   = 2'd0;
        w_lives_n   = 2'(LIVES);
        w_cleared_n = 1'b0;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_start_q    <= 1'b0;
      r_presc      <= '0;
      r_timer      <= '0;
      r_red        <= 1'b0;
      r_win        <= 1'b0;
      r_succ       <= 1'b0;
      r_cleared    <= 1'b0;
      r_level      <= 2'd0;
      r_lives      <= 2'(LIVES);
      r_max_clicks <= 4'(CLICKS_L0);
      r_max_steps  <= 4'(STEPS);
    end else begin
      r_state   <= w_state_n;
      r_level   <= w_level_n;
      r_lives   <= w_lives_n;
      r_cleared <= w_cleared_n;
      r_start_q <= start;
      r_win     <= w_stay && (position == r_max_steps);
      if (r_state == S_PLAY) r_succ <= w_won;
      if (w_state_n == S_ARM) begin
        r_max_clicks <= clicks(w_level_n);
        r_max_steps  <= 4'(STEPS);
      end
      // Leaving PLAY discards any toggle due this cycle and forces green.
      if (r_state == S_ARM) begin
        r_presc <= '0;
        r_timer <= green_len(r_level);
        r_red   <= 1'b0;
      end else if (w_stay) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          r_timer <= w_timer_dn != '0 ? w_timer_dn : (r_red ? green_len(r_level) : red_len(r_level));
          r_red   <= w_timer_dn == '0 ? ~r_red : r_red;
        end
      end else begin
        r_red <= 1'b0;
      end
    end
  end

  assign enable     = r_state == S_PLAY;
  assign round_done = r_state == S_RESULT;
  assign game_over  = r_state == S_OVER;
  assign red        = r_red;
  assign win        = r_win;
  assign max_clicks = r_max_clicks;
  assign max_steps  = r_max_steps;
  assign level      = r_level;
  assign lives      = r_lives;
  assign cleared    = r_cleared;
endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round/level sequencer sitting above game_logic; owns every game_logic configuration and control input (enable, red, win, max_clicks, max_steps).
- Runs the red/green light schedule and detects the finish line from the player position.
- Consumes game_logic status_code to advance levels, deduct lives and end the game.
- Single clock domain, same clock as game_logic.

Parameters:
- LEVELS, 4, number of levels (2..4); level counter is 2 bits.
- LIVES, 3, lives at game start (1..3).
- TICK_DIV, 16, clk cycles per light tick (>=2).
- GREEN_BASE, 6, green-phase length in ticks at level 0.
- RED_BASE, 4, red-phase length in ticks at level 0.
- CLICKS_L0, 14, max_clicks at level 0.
- STEPS, 14, max_steps at every level.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  start button level; registered internally, acts on its 0->1 edge.
- status_code  in  4  from game_logic: 4'd1 PLAYING, 4'd2 WON, 4'd3 LOST; all other values ignored.
- position  in  4  player position from game_logic.
- enable  out  1  game_logic enable.
- red  out  1  1 = red light (moving is illegal), 0 = green.
- win  out  1  finish-line reached, to game_logic.
- max_clicks  out  4  click budget for the current round.
- max_steps  out  4  step target for the current round.
- level  out  2  current level, 0-based.
- lives  out  2  lives remaining.
- round_done  out  1  one-cycle pulse when a round ends.
- game_over  out  1  high in state OVER.
- cleared  out  1  high in OVER when all levels were won.

Behaviour:
- Reset values:
  - state = IDLE; enable, red, win, round_done, game_over, cleared = 0.
  - level = 0; lives = LIVES; max_clicks = CLICKS_L0; max_steps = STEPS.
  - Prescaler, phase timer and start edge register = 0.
- Start edge: start_q is start delayed one cycle; the edge is start & ~start_q.
- IDLE:
  - Outputs idle.
  - Start edge -> ARM with level = 0, lives = LIVES.
- ARM (exactly 1 cycle):
  - enable = 0.
  - max_clicks = CLICKS_L0 - 2*level, saturating at 4 minimum.
  - max_steps = STEPS.
  - Light = green, phase timer = green length, prescaler cleared, win = 0.
  - Next state PLAY.
- PLAY:
  - enable = 1.
  - Prescaler counts 0..TICK_DIV-1 and emits a tick on wrap.
  - Each tick decrements the phase timer. When the timer reaches 0, toggle red and reload:
    - green length = GREEN_BASE - level, minimum 2;
    - red length = RED_BASE + level.
  - win is registered: win = (position == max_steps). It is 1 cycle late and is cleared outside PLAY.
  - status_code == 2 -> RESULT with success.
  - status_code == 3 -> RESULT with failure.
  - Status takes priority over a coincident light toggle; the toggle is discarded.
  - Start edges are ignored.
- RESULT (1 cycle):
  - enable = 0, red = 0, round_done = 1.
  - On success: if level == LEVELS-1, go to OVER with cleared = 1; otherwise level + 1 and go to ARM.
  - On failure: lives - 1. If the result is 0, go to OVER with cleared = 0; otherwise go to ARM at the same level.
- OVER:
  - game_over = 1, enable = 0; cleared holds its value.
  - Start edge -> ARM with level = 0, lives = LIVES and cleared = 0.
- Status sampling: status_code is sampled only in PLAY; any value in the other states has no effect.
- Reset mid-round: asynchronous return to the reset values above. enable drops immediately, and no round_done pulse is generated.
- Counter safety: all counters saturate or reload; none wraps.

Test Plan:
- Test parameters: TICK_DIV = 2, GREEN_BASE = 3, RED_BASE = 2.
- Reset, then start edge -> ARM 1 cycle, then PLAY with enable = 1, max_clicks = 14, max_steps = 14, red = 0; red rises after 6 clk and falls 4 clk later.
- In PLAY at level 0, drive position = 14 -> win = 1 one cycle later. Then status_code = 2 -> round_done pulse, level = 1, max_clicks = 12, green 4 clk / red 6 clk.
- status_code = 3 three times with LIVES = 3 -> lives 2, 1, 0, then OVER with game_over = 1, cleared = 0, enable = 0.
- Win all 4 levels -> max_clicks sequence 14, 12, 10, 8; OVER with cleared = 1. A new start edge restores level = 0, lives = 3, cleared = 0.
- status_code = 2 on the same cycle a phase toggle is due -> RESULT taken, red = 0, no toggle. Hold start high for the whole round -> only one ARM occurs.
- Assert rst mid-PLAY with red = 1 -> enable, red and win are 0 immediately, level = 0, lives = 3, state IDLE, no round_done pulse.
